bus_ram_slave: RTL and testbench
================================

// Module: bus_ram_slave
// PURPOSE
//  Word-organised RAM target on the single-master core bus; consumes bus requests (en/wr/addr/data/byte_en)
//  and returns registered read data plus a one-cycle ack after a programmable number of wait states.
//  Sits directly downstream of the core bus adapter; serves both instruction fetches and data loads/stores.
//  Out-of-window addresses are still acked (master never hangs) and flagged via o_decode_err.
// PARAMETERS
//  DEPTH        1024          RAM size in 32-bit words; power of two, >= 2
//  WAIT_CYCLES  2             wait states between request acceptance and access; 0..15
//  BASE_ADDR    32'h0000_0000 byte address of word 0; aligned to 4*DEPTH
// PORTS
//  i_clk         in   1   clock; all logic on rising edge
//  i_rst         in   1   synchronous, active-high reset
//  i_bus_en      in   1   request valid; master holds high until it samples o_ack
//  i_wr_en       in   1   1 = write, 0 = read; stable while i_bus_en high
//  i_addr        in   32  byte address; bits [1:0] ignored
//  i_wr_data     in   32  write data, byte lane k = bits [8k+7:8k]
//  i_byte_en     in   4   write byte-lane enables; ignored for reads
//  o_ack         out  1   one-cycle completion pulse
//  o_rd_data     out  32  read data, valid only while o_ack high on a read
//  o_decode_err  out  1   pulses with o_ack when request address fell outside the window
// BEHAVIOUR
//  Reset (i_rst=1 at edge): state=IDLE, o_ack=0, o_rd_data=0, o_decode_err=0; RAM contents not reset.
//  Reset wins over every other event, incl. mid-WAIT: request dropped, no RAM write, no ack.
//  FSM states IDLE, WAIT, ACK:
//   IDLE: i_bus_en=1 at edge -> latch wr_en/addr/wr_data/byte_en; hit = (addr - BASE_ADDR) < 4*DEPTH
//         (32-bit unsigned compare); load wait counter = WAIT_CYCLES; go WAIT, or directly perform
//         access and go ACK when WAIT_CYCLES=0.
//   WAIT: i_bus_en=0 at edge -> abort to IDLE, no access, no ack. Else counter decrements; at edge
//         where counter==1 perform access and go ACK. WAIT lasts exactly WAIT_CYCLES cycles.
//   ACK:  o_ack=1 for exactly this cycle; i_bus_en ignored; unconditional -> IDLE.
//  Access (single edge): index = (addr - BASE_ADDR)[log2(DEPTH)+1:2].
//   write & hit: RAM[index] byte lane k <= wr_data lane k iff byte_en[k]; byte_en=0000 writes nothing.
//   read & hit: o_rd_data <= RAM[index].
//   miss: no RAM write; o_rd_data <= 0; o_decode_err <= 1.
//  o_rd_data=0 and o_decode_err=0 in every non-ACK cycle and on write acks.
//  Latency: request high in cycle T -> o_ack high in cycle T+WAIT_CYCLES+1.
//  Back-to-back: new request accepted in IDLE the cycle after ACK; no request is accepted while in
//   WAIT or ACK. A request held high through ACK is re-accepted as a new one.
//  i_wr_en/i_addr changes while in WAIT have no effect (latched copies used).
//  Throughput: one transfer per WAIT_CYCLES+2 cycles.
// TESTING
//  1 WAIT_CYCLES=2: write 0xDEADBEEF, be=1111 @0x10 (req cycle 5) -> ack cycle 8; read @0x10 -> rd_data 0xDEADBEEF with ack.
//  2 Byte lanes: mem[0x20]=0x11223344, write 0xAABBCCDD be=0101 -> read returns 0x11BB33DD.
//  3 Decode miss: BASE_ADDR=0, DEPTH=1024, read @0x1000 -> ack, rd_data 0, decode_err 1; write there -> no RAM change.
//  4 Abort: drop i_bus_en in WAIT -> no ack ever; prior write data at that address unchanged.
//  5 Reset mid-WAIT of write 0x5 @0x4 -> no ack, mem[0x4] keeps old value, outputs all 0 next cycle.
//  6 WAIT_CYCLES=0: read request cycle T -> ack cycle T+1; back-to-back reads ack every 2 cycles.

Source files
------------

// File: rtl/bus_ram_slave.sv
// Word-organised RAM target for the core bus, with a programmable number of wait states.
// Out-of-window requests are still acked, so the master never hangs, and are flagged with o_decode_err.
module bus_ram_slave #(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_en,
  input  logic        i_wr_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_byte_en,
  output logic        o_ack,
  output logic [31:0] o_rd_data,
  output logic        o_decode_err
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [31:0] off_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rd_data_q, rd_data_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic          take_req;
  logic          access;
  logic          acc_wr;
  logic          acc_hit;
  logic [31:0]   acc_off;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic [AW-1:0] acc_idx;
  logic [31:0]   in_off;

  assign in_off = i_addr - BASE_ADDR;

  // With zero wait states the access happens on the accepting edge, so it uses the live inputs.
  assign acc_wr    = take_req ? i_wr_en   : wr_q;
  assign acc_off   = take_req ? in_off    : off_q;
  assign acc_wdata = take_req ? i_wr_data : wdata_q;
  assign acc_be    = take_req ? i_byte_en : be_q;
  assign acc_hit   = acc_off < WIN_BYTES;
  assign acc_idx   = acc_off[AW+1:2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    take_req = 1'b0;
    access   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_bus_en) begin
          take_req = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = S_ACK;
          end else begin
            cnt_d   = WAIT_LD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!i_bus_en) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd1) begin
          access  = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_data_d = 32'd0;
    err_d     = 1'b0;
    if (access) begin
      if (!acc_hit) begin
        err_d = 1'b1;
      end else if (!acc_wr) begin
        rd_data_d = mem[acc_idx];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      off_q     <= 32'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      rd_data_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      if (take_req) begin
        wr_q    <= i_wr_en;
        off_q   <= in_off;
        wdata_q <= i_wr_data;
        be_q    <= i_byte_en;
      end
    end
  end

  // RAM has no reset; a reset edge must still suppress any pending write.
  always_ff @(posedge i_clk) begin
    if (!i_rst && access && acc_wr && acc_hit) begin
      for (int k = 0; k < 4; k++) begin
        if (acc_be[k]) mem[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
      end
    end
  end

  assign o_ack        = (state_q == S_ACK);
  assign o_rd_data    = rd_data_q;
  assign o_decode_err = err_q;

endmodule

// File: tb/tb_bus_ram_slave.sv
// Scoreboard bench: u0 has two wait states, u1 has none; a negedge monitor checks every ack
// (data, error flag, cycle) against the queue and checks that outputs stay zero between acks.
module tb_bus_ram_slave;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        en[2], wr[2], ack[2], err[2];
  logic [31:0] addr[2], wdata[2], rdata[2];
  logic [3:0]  be[2];

  bus_ram_slave #(.DEPTH(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_bus_en(en[0]), .i_wr_en(wr[0]), .i_addr(addr[0]),
    .i_wr_data(wdata[0]), .i_byte_en(be[0]), .o_ack(ack[0]), .o_rd_data(rdata[0]),
    .o_decode_err(err[0]));

  bus_ram_slave #(.DEPTH(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_bus_en(en[1]), .i_wr_en(wr[1]), .i_addr(addr[1]),
    .i_wr_data(wdata[1]), .i_byte_en(be[1]), .o_ack(ack[1]), .o_rd_data(rdata[1]),
    .o_decode_err(err[1]));

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk_err;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int i);
    exp_t e;
    if (ack[i]) begin
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
        check($sformatf("u%0d_unexpected_ack", i), 32'(ack[i]), 32'd0);
      end else begin
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("u%0d_rd_data", i), rdata[i], e.rd);
        if (e.chk_err) check($sformatf("u%0d_decode_err", i), 32'(err[i]), 32'(e.err));
        check($sformatf("u%0d_ack_cycle", i), 32'(cyc), 32'(e.cyc));
      end
    end else begin
      check($sformatf("u%0d_idle_rd_data", i), rdata[i], 32'd0);
      check($sformatf("u%0d_idle_err", i), 32'(err[i]), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int i = 0; i < 2; i++) mon(i);
    end
  end

  // Called at a negedge; returns at the negedge of the ack cycle with the request still driven.
  task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] erd, input logic eerr,
                       input logic cerr, input bit b2b);
    exp_t e;
    bit   got;
    int   wcyc;
    wcyc = (i == 0) ? 2 : 0;
    e.rd = erd; e.err = eerr; e.chk_err = cerr;
    e.cyc = cyc + wcyc + 1 + (b2b ? 1 : 0);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    en[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (ack[i]) got = 1'b1;
    end
    check($sformatf("u%0d_ack_seen", i), 32'(got), 32'd1);
  endtask

  task automatic drop(input int i);
    en[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr_op(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    issue(i, 1'b1, a, d, b, 32'd0, 1'b0, 1'b1, 1'b0);
    drop(i);
  endtask

  task automatic rd_op(input int i, input logic [31:0] a, input logic [31:0] erd, input logic eerr);
    issue(i, 1'b0, a, 32'd0, 4'd0, erd, eerr, 1'b1, 1'b0);
    drop(i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0; be[i] = 4'd0;
    end
    @(negedge clk);
    mon_on = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic write/read with two wait states
    wr_op(0, 32'h10, 32'hDEADBEEF, 4'hF);
    rd_op(0, 32'h10, 32'hDEADBEEF, 1'b0);

    // Byte lanes, and an all-disabled write that must change nothing
    wr_op(0, 32'h20, 32'h11223344, 4'hF);
    wr_op(0, 32'h20, 32'hAABBCCDD, 4'b0101);
    rd_op(0, 32'h20, 32'h11BB33DD, 1'b0);
    wr_op(0, 32'h20, 32'hFFFFFFFF, 4'b0000);
    rd_op(0, 32'h20, 32'h11BB33DD, 1'b0);

    // Window edges: last word hits, one past and wrapped-below addresses miss
    wr_op(0, 32'h0, 32'h01020304, 4'hF);
    wr_op(0, 32'hFFC, 32'h5A5A5A5A, 4'hF);
    rd_op(0, 32'hFFC, 32'h5A5A5A5A, 1'b0);
    rd_op(0, 32'h1000, 32'h0, 1'b1);
    rd_op(0, 32'hFFFF_FFFC, 32'h0, 1'b1);
    issue(0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0, 1'b0, 1'b0);
    drop(0);
    rd_op(0, 32'h0, 32'h01020304, 1'b0);

    // Abort: drop the request during WAIT; nothing pushed, so any ack is flagged
    wr_op(0, 32'h30, 32'h12345678, 4'hF);
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'h0BADBAD0; be[0] = 4'hF;
    @(negedge clk);
    en[0] = 1'b0;
    repeat (5) @(negedge clk);
    rd_op(0, 32'h30, 32'h12345678, 1'b0);

    // Reset while a write sits in WAIT
    wr_op(0, 32'h4, 32'h0000AAAA, 4'hF);
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h4; wdata[0] = 32'h5; be[0] = 4'hF;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en[0] = 1'b0;
    repeat (4) @(negedge clk);
    rd_op(0, 32'h4, 32'h0000AAAA, 1'b0);

    // Request held through ACK is re-accepted (two wait states)
    issue(0, 1'b0, 32'h10, 32'd0, 4'd0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    issue(0, 1'b0, 32'h20, 32'd0, 4'd0, 32'h11BB33DD, 1'b0, 1'b1, 1'b1);
    drop(0);

    // Zero wait states: ack next cycle, back-to-back reads every two cycles
    wr_op(1, 32'h100, 32'h0A0A0A0A, 4'hF);
    wr_op(1, 32'h104, 32'h0B0B0B0B, 4'hF);
    wr_op(1, 32'h108, 32'h0C0C0C0C, 4'hF);
    issue(1, 1'b0, 32'h100, 32'd0, 4'd0, 32'h0A0A0A0A, 1'b0, 1'b1, 1'b0);
    issue(1, 1'b0, 32'h104, 32'd0, 4'd0, 32'h0B0B0B0B, 1'b0, 1'b1, 1'b1);
    issue(1, 1'b0, 32'h108, 32'd0, 4'd0, 32'h0C0C0C0C, 1'b0, 1'b1, 1'b1);
    drop(1);
    rd_op(1, 32'h2000, 32'h0, 1'b1);

    repeat (5) @(negedge clk);
    check("u0_queue_drained", 32'(q0.size()), 32'd0);
    check("u1_queue_drained", 32'(q1.size()), 32'd0);
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
